gf2_poly_div: RTL and testbench



---
 rtl/gf2_poly_div.sv | 126 ++++++++++++
 tb/tb_gf2_poly_div.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_poly_div.sv
// Iterative GF(2) polynomial divider: dividend = quotient*divisor ^ remainder, one bit per clock.
// Define GF2_POLY_DIV_EARLY_DONE_EN to stop once i reaches deg(divisor) (variable latency).
module gf2_poly_div #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-2:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-2:0] quotient,
    output logic [N-2:0]   remainder,
    output logic           div_by_zero
);

    localparam int QW = 2*N-1;
    localparam int IW = $clog2(QW);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t          r_state;
    logic [QW-1:0]   r_rem;
    logic [QW-1:0]   r_quo;
    logic [IW-1:0]   r_i;
    logic [IW-1:0]   r_deg;
    logic [N-1:0]    r_dvs;

    logic [IW-1:0]   w_deg;
    logic [IW-1:0]   w_shift;
    logic            w_hit;
    logic            w_last;
    logic [QW-1:0]   w_dvs_sh;
    logic [QW-1:0]   w_rem_nxt;
    logic [QW-1:0]   w_quo_nxt;

    // Highest set bit of the incoming divisor; later indices override earlier ones.
    always_comb begin
        w_deg = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (divisor[k]) w_deg = IW'(k);
        end
    end

    always_comb begin
        w_shift   = r_i - r_deg;
        w_hit     = (r_i >= r_deg) && r_rem[r_i];
        w_dvs_sh  = QW'(r_dvs) << w_shift;
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        if (w_hit) begin
            w_rem_nxt          = r_rem ^ w_dvs_sh;
            w_quo_nxt[w_shift] = 1'b1;
        end
`ifdef GF2_POLY_DIV_EARLY_DONE_EN
        w_last = (r_i == r_deg);
`else
        w_last = (r_i == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_i         <= '0;
            r_deg       <= '0;
            r_dvs       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_rem    <= dividend;
                        r_quo    <= '0;
                        r_deg    <= w_deg;
                        r_dvs    <= divisor;
                        r_i      <= IW'(QW-1);
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_state     <= DONE;
                            out_valid   <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '0;
                            remainder   <= '0;
                        end else begin
                            r_state <= DIV;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_i   <= r_i - 1'b1;
                    if (w_last) begin
                        r_state     <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= w_quo_nxt;
                        remainder   <= w_rem_nxt[N-2:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_poly_div.sv
// Scoreboard bench for gf2_poly_div: driver pushes hand-computed results, negedge monitor pops on handshake.
module tb_gf2_poly_div;

    localparam int N  = 8;
    localparam int QW = 2*N-1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [QW-1:0] dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] quotient;
    logic [N-2:0]  remainder;
    logic          div_by_zero;

    gf2_poly_div #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [QW-1:0] q;
        logic [N-2:0]  r;
        logic          dz;
        int            lat;
        int            acc;
    } exp_t;

    typedef struct {
        logic [QW-1:0] dvd;
        logic [N-1:0]  dvs;
        logic [QW-1:0] q;
        logic [N-2:0]  r;
        logic          dz;
        int            deg;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Latency counted in edges after the accept edge; a zero divisor answers on the accept edge itself.
    function automatic int exp_lat(input int deg, input logic dz);
        if (dz) return 0;
`ifdef GF2_POLY_DIV_EARLY_DONE_EN
        return QW - deg;
`else
        return QW;
`endif
    endfunction

    // Driver phase: always 1 time unit after a rising edge.
    task automatic issue(input vec_t v, input bit push);
        int   k;
        exp_t e;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) check("issue_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = v.dvd;
        divisor  = v.dvs;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.q   = v.q;
            e.r   = v.r;
            e.dz  = v.dz;
            e.lat = exp_lat(v.deg, v.dz);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: records the rise of out_valid, compares when the result is consumed.
    initial begin : monitor
        bit   prev_v;
        int   rise_cyc;
        exp_t e;
        prev_v   = 1'b0;
        rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) rise_cyc = cyc;
                prev_v = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("quotient",    32'(quotient),       32'(e.q));
                        check("remainder",   32'(remainder),      32'(e.r));
                        check("div_by_zero", 32'(div_by_zero),    32'(e.dz));
                        check("latency",     32'(rise_cyc - e.acc), 32'(e.lat));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[10] = '{
        '{15'h00AD, 8'h13, 15'h000B, 7'h00, 1'b0, 4},
        '{15'h00AE, 8'h13, 15'h000B, 7'h03, 1'b0, 4},
        '{15'h00AC, 8'h13, 15'h000B, 7'h01, 1'b0, 4},
        '{15'h7FFF, 8'h01, 15'h7FFF, 7'h00, 1'b0, 0},
        '{15'h4000, 8'h80, 15'h0080, 7'h00, 1'b0, 7},
        '{15'h1234, 8'h00, 15'h0000, 7'h00, 1'b1, 0},
        '{15'h0005, 8'h07, 15'h0001, 7'h02, 1'b0, 2},
        '{15'h00FF, 8'h03, 15'h0055, 7'h00, 1'b0, 1},
        '{15'h0000, 8'h13, 15'h0000, 7'h00, 1'b0, 4},
        '{15'h007F, 8'h80, 15'h0000, 7'h7F, 1'b0, 7}
    };

    initial begin : driver
        int   k;
        vec_t v;

        #12;
        check("rst_in_ready",  32'(in_ready),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_quotient",  32'(quotient),    32'd0);
        check("rst_remainder", 32'(remainder),   32'd0);
        check("rst_dbz",       32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[j]) begin
            issue(vecs[j], 1'b1);
            wait_drain();
        end
        check("hold_after_idle_q", 32'(quotient),  32'h0);
        check("hold_after_idle_r", 32'(remainder), 32'h7F);

        // Backpressure: result must hold and new requests be ignored.
        out_ready = 1'b0;
        issue(vecs[0], 1'b1);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            dividend = 15'h1234;
            divisor  = 8'h05;
            @(posedge clk); #1;
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_quotient",  32'(quotient),  32'h000B);
            check("bp_remainder", 32'(remainder), 32'h00);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_hold_q",    32'(quotient),  32'h000B);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_accept_valid", 32'(out_valid), 32'd0);
        check("bp_no_accept_ready", 32'(in_ready),  32'd1);

        // Reset in the middle of a division, then a clean run.
        v = vecs[0];
        issue(v, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_quotient",  32'(quotient),  32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(v, 1'b1);
        wait_drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
